mem_port_arbiter: RTL and testbench

Arbitrates the single-port 8-bit `mem` instance between the instruction-fetch requester and the load/store requester. It turns two valid/ready request streams into one memory access per cycle and routes the 1-cycle-latency read data back to the requester that issued it. Load/store has priority, and a starvation counter bounds how long fetch can be starved. A fetch flush input discards fetch data after a branch redirect.

---
 rtl/core_pkg.sv | 18 +
 rtl/arb_starve_ctr.sv | 29 ++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core memory-port logic.
package core_pkg;

  localparam int unsigned MEM_AW = 8;
  localparam int unsigned MEM_DW = 8;

  // Data returned on ls_rsp_data when a store is acknowledged.
  localparam logic [MEM_DW-1:0] STORE_ACK_DATA = 8'h00;

  // Which requester owns the memory read data returning this cycle.
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    IF    = 2'd1,
    LS_RD = 2'd2,
    LS_WR = 2'd3
  } mem_owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive fetch denials; flags when fetch must win.
module arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt;

  assign at_limit = (cnt == CW'(STARVE_LIMIT));

  // Count denials, holding at the limit; a fetch grant or idle fetch clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store requesters and
// steers the 1-cycle-latency read data back to whichever side issued it.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [MEM_AW-1:0] if_req_addr,
  output logic              if_req_ready,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [MEM_DW-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  input  logic              ls_req_wr,
  input  logic [MEM_AW-1:0] ls_req_addr,
  input  logic [MEM_DW-1:0] ls_req_wdata,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [MEM_DW-1:0] ls_rsp_data,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_data_in,
  input  logic [MEM_DW-1:0] mem_data_out
);

  logic       if_gnt;
  logic       ls_gnt;
  logic       at_limit;
  mem_owner_e owner;
  mem_owner_e owner_next;

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (if_req_valid && !if_flush && ls_gnt),
    .clr      (if_gnt || !if_req_valid),
    .at_limit (at_limit)
  );

  // Grant: ls has priority unless fetch has hit its starvation limit;
  // flush removes fetch from contention, and reset blocks both.
  always_comb begin
    if_gnt = rst_n && if_req_valid && !if_flush && (!ls_req_valid || at_limit);
    ls_gnt = rst_n && ls_req_valid && !if_gnt;
    if_req_ready = if_gnt;
    ls_req_ready = ls_gnt;
  end

  // Drive the memory port from the granted request and note the new owner.
  always_comb begin
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    owner_next  = NONE;
    if (if_gnt) begin
      mem_enable = 1'b1;
      mem_addr   = if_req_addr;
      owner_next = IF;
    end else if (ls_gnt) begin
      mem_enable = 1'b1;
      mem_addr   = ls_req_addr;
      if (ls_req_wr) begin
        mem_wr      = 1'b1;
        mem_data_in = ls_req_wdata;
        owner_next  = LS_WR;
      end else begin
        owner_next = LS_RD;
      end
    end
  end

  // Owner of the access whose response is due next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= NONE;
    end else begin
      owner <= owner_next;
    end
  end

  // Steer returning data; data outputs stay zero when not valid.
  always_comb begin
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    ls_rsp_valid = 1'b0;
    ls_rsp_data  = '0;
    unique case (owner)
      IF: begin
        if (!if_flush) begin
          if_rsp_valid = 1'b1;
          if_rsp_data  = mem_data_out;
        end
      end
      LS_RD: begin
        ls_rsp_valid = 1'b1;
        ls_rsp_data  = mem_data_out;
      end
      LS_WR: begin
        ls_rsp_valid = 1'b1;
        ls_rsp_data  = STORE_ACK_DATA;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of the arbiter's key scenarios, then randomized traffic
// scored against a queue-based reference model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       if_req_valid = 1'b0;
  logic [7:0] if_req_addr = '0;
  logic       if_req_ready;
  logic       if_flush = 1'b0;
  logic       if_rsp_valid;
  logic [7:0] if_rsp_data;
  logic       ls_req_valid = 1'b0;
  logic       ls_req_wr = 1'b0;
  logic [7:0] ls_req_addr = '0;
  logic [7:0] ls_req_wdata = '0;
  logic       ls_req_ready;
  logic       ls_rsp_valid;
  logic [7:0] ls_rsp_data;
  logic       mem_enable;
  logic       mem_wr;
  logic [7:0] mem_addr;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out = '0;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_wr(ls_req_wr), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Physical single-port memory with 1-cycle read latency.
  logic [7:0] phys [256];
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_wr) phys[mem_addr] <= mem_data_in;
      else        mem_data_out   <= phys[mem_addr];
    end
  end

  // Reference model state.
  logic [7:0] ref_mem [256];
  int         denials = 0;
  bit         rand_on = 0;
  bit         pend_if = 0, pend_ls = 0;
  logic [7:0] pend_if_data, pend_ls_data;
  logic [7:0] if_q [$];
  logic [7:0] ls_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req_valid = 0; if_flush = 0; ls_req_valid = 0; ls_req_wr = 0;
  endtask

  // Reference model: evaluated mid-cycle once inputs are stable.
  initial forever begin
    @(negedge clk);
    if (rand_on) begin
      bit exp_if, exp_ls;
      if (pend_if && !if_flush) if_q.push_back(pend_if_data);
      if (pend_ls) ls_q.push_back(pend_ls_data);
      exp_if = if_req_valid && !if_flush && (!ls_req_valid || denials == LIMIT);
      exp_ls = ls_req_valid && !exp_if;
      chk("rand_if_ready", int'(if_req_ready), int'(exp_if));
      chk("rand_ls_ready", int'(ls_req_ready), int'(exp_ls));
      chk("rand_mem_enable", int'(mem_enable), int'(exp_if || exp_ls));
      chk("rand_mem_wr", int'(mem_wr), int'(exp_ls && ls_req_wr));
      chk("rand_mem_addr", int'(mem_addr),
          exp_if ? int'(if_req_addr) : (exp_ls ? int'(ls_req_addr) : 0));
      chk("rand_mem_data_in", int'(mem_data_in),
          (exp_ls && ls_req_wr) ? int'(ls_req_wdata) : 0);
      pend_if = exp_if;
      pend_ls = exp_ls;
      if (exp_if) pend_if_data = ref_mem[if_req_addr];
      if (exp_ls) begin
        if (ls_req_wr) begin
          pend_ls_data = 8'h00;
          ref_mem[ls_req_addr] = ls_req_wdata;
        end else begin
          pend_ls_data = ref_mem[ls_req_addr];
        end
      end
      if (exp_if || !if_req_valid) denials = 0;
      else if (!if_flush && exp_ls) denials = (denials < LIMIT) ? denials + 1 : LIMIT;
    end
  end

  // Response monitor: pops expected data whenever a response is due or shown.
  initial forever begin
    @(negedge clk);
    #1;
    if (rand_on) begin
      if (if_rsp_valid) begin
        if (if_q.size() == 0) chk("if_rsp_unexpected", 1, 0);
        else chk("if_rsp_data", int'(if_rsp_data), int'(if_q.pop_front()));
      end else begin
        chk("if_rsp_idle_data", int'(if_rsp_data), 0);
        if (if_q.size() != 0) begin
          chk("if_rsp_missing", 0, 1);
          void'(if_q.pop_front());
        end
      end
      if (ls_rsp_valid) begin
        if (ls_q.size() == 0) chk("ls_rsp_unexpected", 1, 0);
        else chk("ls_rsp_data", int'(ls_rsp_data), int'(ls_q.pop_front()));
      end else begin
        chk("ls_rsp_idle_data", int'(ls_rsp_data), 0);
        if (ls_q.size() != 0) begin
          chk("ls_rsp_missing", 0, 1);
          void'(ls_q.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      phys[i] = 8'($urandom);
      ref_mem[i] = phys[i];
    end
    phys[8'h10] = 8'hA5;
    ref_mem[8'h10] = 8'hA5;

    // Reset with both requesters valid.
    if_req_valid = 1; if_req_addr = 8'h10;
    ls_req_valid = 1; ls_req_addr = 8'h01;
    repeat (2) cyc();
    chk("rst_if_ready", int'(if_req_ready), 0);
    chk("rst_ls_ready", int'(ls_req_ready), 0);
    chk("rst_mem_enable", int'(mem_enable), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_if_rsp_valid", int'(if_rsp_valid), 0);
    chk("rst_ls_rsp_valid", int'(ls_rsp_valid), 0);
    rst_n = 1;
    #1;
    chk("rst_release_ls_ready", int'(ls_req_ready), 1);
    idle();
    cyc();
    cyc();

    // Fetch read.
    if_req_valid = 1; if_req_addr = 8'h10;
    #1;
    chk("fetch_ready", int'(if_req_ready), 1);
    chk("fetch_mem_addr", int'(mem_addr), 8'h10);
    cyc();
    idle();
    #1;
    chk("fetch_rsp_valid", int'(if_rsp_valid), 1);
    chk("fetch_rsp_data", int'(if_rsp_data), 8'hA5);
    chk("fetch_ls_rsp_valid", int'(ls_rsp_valid), 0);
    cyc();

    // Starvation pattern: ls 4 cycles, fetch on the 5th, repeating.
    if_req_valid = 1; if_req_addr = 8'h00;
    ls_req_valid = 1; ls_req_addr = 8'h01; ls_req_wr = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("starve_if_ready", int'(if_req_ready), (k % 5 == 4) ? 1 : 0);
      chk("starve_ls_ready", int'(ls_req_ready), (k % 5 == 4) ? 0 : 1);
      cyc();
    end
    idle();
    cyc();

    // Store then fetch of the same address.
    ls_req_valid = 1; ls_req_wr = 1; ls_req_addr = 8'h20; ls_req_wdata = 8'h3C;
    #1;
    chk("store_ready", int'(ls_req_ready), 1);
    chk("store_mem_wr", int'(mem_wr), 1);
    chk("store_mem_data_in", int'(mem_data_in), 8'h3C);
    cyc();
    idle();
    if_req_valid = 1; if_req_addr = 8'h20;
    #1;
    chk("store_ack_valid", int'(ls_rsp_valid), 1);
    chk("store_ack_data", int'(ls_rsp_data), 0);
    chk("store_fetch_ready", int'(if_req_ready), 1);
    cyc();
    idle();
    #1;
    chk("store_fetch_data", int'(if_rsp_data), 8'h3C);
    chk("store_fetch_valid", int'(if_rsp_valid), 1);
    ref_mem[8'h20] = 8'h3C;
    cyc();

    // Flush suppresses the returning fetch and blocks a new fetch grant.
    if_req_valid = 1; if_req_addr = 8'h10;
    #1;
    chk("flush_pre_ready", int'(if_req_ready), 1);
    cyc();
    if_flush = 1;
    #1;
    chk("flush_rsp_valid", int'(if_rsp_valid), 0);
    chk("flush_rsp_data", int'(if_rsp_data), 0);
    chk("flush_if_ready", int'(if_req_ready), 0);
    cyc();
    idle();
    #1;
    chk("flush_after_valid", int'(if_rsp_valid), 0);
    cyc();

    // Reset mid-operation.
    ls_req_valid = 1; ls_req_wr = 0; ls_req_addr = 8'h10;
    #1;
    chk("midrst_ls_ready", int'(ls_req_ready), 1);
    cyc();
    idle();
    #1;
    chk("midrst_rsp_before", int'(ls_rsp_valid), 1);
    rst_n = 0;
    #1;
    chk("midrst_rsp_drop", int'(ls_rsp_valid), 0);
    cyc();
    cyc();
    rst_n = 1;
    #1;
    chk("midrst_after_valid", int'(ls_rsp_valid), 0);
    cyc();
    #1;
    chk("midrst_after2_valid", int'(ls_rsp_valid), 0);
    cyc();

    // Randomized traffic against the reference model.
    rand_on = 1;
    cyc();
    for (int n = 0; n < 2000; n++) begin
      if_req_valid = ($urandom_range(0, 3) != 0);
      if_req_addr  = 8'($urandom_range(0, 15));
      if_flush     = ($urandom_range(0, 9) == 0);
      ls_req_valid = ($urandom_range(0, 2) != 0);
      ls_req_wr    = $urandom_range(0, 1) == 1;
      ls_req_addr  = 8'($urandom_range(0, 15));
      ls_req_wdata = 8'($urandom);
      cyc();
    end
    idle();
    cyc();
    cyc();
    cyc();
    rand_on = 0;
    chk("if_q_drained", if_q.size(), 0);
    chk("ls_q_drained", ls_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
